// File: rtl/myproject_acc_requant_47s_16s_if.sv
// Stream bundle for the accumulate/requantize block.
//   din        : 47-bit signed product term from the 31ns x 16s multiplier
//   din_valid  : din is valid this cycle
//   din_ready  : block accepts din this cycle
//   dout       : 16-bit signed requantized result
//   dout_valid : dout holds an unconsumed result
//   dout_ready : consumer takes dout this cycle
//   dout_sat   : dout was clipped (qualified by dout_valid)
// The master modport is the environment side (producer + consumer); the slave
// modport is the accumulator block itself.
interface myproject_acc_requant_47s_16s_if;
  logic signed [46:0] din;
  logic               din_valid;
  logic               din_ready;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               dout_sat;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_sat
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_sat
  );
endinterface

// File: rtl/myproject_acc_requant_47s_16s.sv
// Accumulates N_TERMS signed 47-bit product terms, then requantizes the group
// sum to a saturated 16-bit signed result: R = floor((S + 2^(FRAC_SHIFT-1)) /
// 2^FRAC_SHIFT), clipped to [-32768, 32767].
// Ports:
//   ap_clk   : clock, all state on rising edge
//   ap_rst_n : synchronous active-low reset
//   bus      : slave side of the din/dout valid-ready stream bundle
// The result is registered; it appears one cycle after the final term is
// accepted. A pending result blocks input until it is consumed, but a consume
// and a final-term accept on the same edge reload the output with no bubble.
module myproject_acc_requant_47s_16s #(
  parameter int N_TERMS    = 8,
  parameter int FRAC_SHIFT = 15,
  parameter int ACC_WIDTH  = 55
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  myproject_acc_requant_47s_16s_if.slave  bus
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  // Rounding constant and clip limits, all at ACC_WIDTH+1 bits so the
  // rounding add cannot wrap even for a full-scale accumulator.
  localparam logic signed [ACC_WIDTH:0] ROUND_K =
    (ACC_WIDTH+1)'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] MAX_Q =
    {{(ACC_WIDTH-15){1'b0}}, 16'h7fff};
  localparam logic signed [ACC_WIDTH:0] MIN_Q =
    {{(ACC_WIDTH-15){1'b1}}, 16'h8000};

  logic signed [ACC_WIDTH-1:0] acc;
  logic        [CNT_W-1:0]     cnt;

  logic signed [ACC_WIDTH-1:0] din_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH:0]   rnd;
  logic signed [ACC_WIDTH:0]   rq;
  logic                        accept;
  logic                        last;
  logic signed [15:0]          q_val;
  logic                        q_sat;

  // Ready depends only on the output slot: free, or being freed this edge.
  assign bus.din_ready = !bus.dout_valid || bus.dout_ready;
  assign accept        = bus.din_valid && bus.din_ready;
  assign last          = (cnt == LAST_CNT);

  assign din_ext = {{(ACC_WIDTH-47){bus.din[46]}}, bus.din};
  assign sum     = acc + din_ext;

  // Round half toward +inf, then arithmetic shift (floor).
  assign rnd = {sum[ACC_WIDTH-1], sum} + ROUND_K;
  assign rq  = rnd >>> FRAC_SHIFT;

  always_comb begin
    q_val = rq[15:0];
    q_sat = 1'b0;
    if (rq > MAX_Q) begin
      q_val = 16'sh7fff;
      q_sat = 1'b1;
    end else if (rq < MIN_Q) begin
      q_val = -16'sh8000;
      q_sat = 1'b1;
    end
  end

  // Accumulator and term counter.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Output register. dout/dout_sat change only on a result load or reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      bus.dout_valid <= 1'b0;
      bus.dout       <= '0;
      bus.dout_sat   <= 1'b0;
    end else if (accept && last) begin
      bus.dout_valid <= 1'b1;
      bus.dout       <= q_val;
      bus.dout_sat   <= q_sat;
    end else if (bus.dout_ready) begin
      bus.dout_valid <= 1'b0;
    end
  end

endmodule

// File: doc/myproject_acc_requant_47s_16s.md
MYPROJECT_ACC_REQUANT_47S_16S -- requirements
Module: myproject_acc_requant_47s_16s

Interface
REQ-001 The block SHALL have parameter N_TERMS, default 8, giving the number of products summed per output; legal range 2..256.
REQ-002 The block SHALL have parameter FRAC_SHIFT, default 15, giving the right-shift applied to the sum; legal range 1..40.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 55, giving the accumulator width; ACC_WIDTH >= 47 + ceil(log2(N_TERMS)).
REQ-004 The block SHALL use one clock; reset is synchronous and active-low, with ports named ap_clk and ap_rst_n.
REQ-005 The block SHALL have port ap_clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-006 The block SHALL have port ap_rst_n, input, 1 bit: synchronous active-low reset.
REQ-007 The block SHALL have port din, input, 47 bits: signed product term from the upstream 31ns x 16s multiplier.
REQ-008 The block SHALL have port din_valid, input, 1 bit: din is valid this cycle.
REQ-009 The block SHALL have port din_ready, output, 1 bit: the block accepts din this cycle.
REQ-010 The block SHALL have port dout, output, 16 bits: signed requantized result.
REQ-011 The block SHALL have port dout_valid, output, 1 bit: dout holds an unconsumed result.
REQ-012 The block SHALL have port dout_ready, input, 1 bit: the consumer takes dout this cycle.
REQ-013 The block SHALL have port dout_sat, output, 1 bit: dout was clipped; qualified by dout_valid.

Function
REQ-014 A term SHALL be accepted on an edge where din_valid and din_ready are both 1; an output SHALL be consumed on an edge where dout_valid and dout_ready are both 1.
REQ-015 din_ready SHALL equal (!dout_valid || dout_ready) and SHALL be combinational from dout_ready, with no dependence on din_valid.
REQ-016 The block SHALL keep a term counter, 0..N_TERMS-1, and a signed ACC_WIDTH accumulator; din SHALL be sign-extended before addition.
REQ-017 On acceptance with counter < N_TERMS-1: accumulator <= accumulator + din; counter <= counter + 1.
REQ-018 On acceptance with counter == N_TERMS-1: form sum S = accumulator + din; load dout/dout_sat from S; set dout_valid; clear accumulator and counter to 0.
REQ-019 Latency SHALL be exactly one cycle: dout_valid is 1 in the cycle after the final term is accepted.
REQ-020 Requantization SHALL compute R = floor((S + 2^(FRAC_SHIFT-1)) / 2^FRAC_SHIFT), i.e. round half toward +infinity via arithmetic shift.
REQ-021 If R > 32767, dout SHALL be 32767 and dout_sat 1; if R < -32768, dout SHALL be -32768 and dout_sat 1; otherwise dout = R[15:0] and dout_sat 0.
REQ-022 The rounding add SHALL be done at ACC_WIDTH+1 bits so it never wraps.
REQ-023 While dout_valid is 1 and dout_ready is 0, dout, dout_sat and dout_valid SHALL hold, and no term SHALL be accepted.
REQ-024 Consume and final-term acceptance in the same edge SHALL load the new result, leaving dout_valid at 1 with no bubble.
REQ-025 Consume without a new result SHALL clear dout_valid on that edge.
REQ-026 Back-to-back groups at full rate SHALL sustain one term per cycle when dout_ready is held at 1.
REQ-027 dout and dout_sat SHALL be don't-care while dout_valid is 0, but SHALL NOT change except on a result load or reset.

Reset
REQ-028 While ap_rst_n is 0 at a rising edge, the block SHALL set accumulator to 0, counter to 0, dout_valid to 0, dout to 0, and dout_sat to 0.
REQ-029 Reset mid-group SHALL discard the partial sum; the first term accepted after reset SHALL start a new group.
REQ-030 Reset SHALL discard a pending unconsumed result.
REQ-031 din_ready SHALL read 1 during and immediately after reset.

Verification (defaults N_TERMS=8, FRAC_SHIFT=15)
REQ-032 The bench SHALL drive eight terms of 32768 with dout_ready=1 -> dout=8, dout_sat=0, and dout_valid high for exactly one cycle, one cycle after the 8th term.
REQ-033 The bench SHALL cover rounding with group sums 16384, -16384 and -16385 -> dout=1, 0 and -1 respectively.
REQ-034 The bench SHALL drive eight terms of 2^40 -> dout=32767, dout_sat=1; and eight terms of -2^40 -> dout=-32768, dout_sat=1.
REQ-035 The bench SHALL hold dout_ready=0 after a result with din_valid=1 -> din_ready=0; dout stays stable for 5 cycles; then dout_ready=1 -> consumed and the next group proceeds without loss.
REQ-036 The bench SHALL apply three terms of 1000000, then ap_rst_n=0 for one cycle, then eight terms of 32768 -> dout=8, with no contribution from the pre-reset terms.
REQ-037 The bench SHALL stream 32 terms continuously with dout_ready=1 and din_valid=1 -> 4 results, din_ready never low, and an output spacing of 8 cycles.
